// File: rtl/rts_pkg.sv
// Shared types and helpers for the RTS BIST test-sequencing controller.
package rts_pkg;

  typedef enum logic [1:0] {
    RESET   = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } rts_state_t;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/rts_if.sv
// Control bundle from the RTS controller to the CPU, pattern generators and compactors.
// Optional status signals (busy, tst_cycle) exist only when RTS_STATUS_EN is defined.
interface rts_if #(
  parameter int NUM_TST_CYCL = 100
);
  import rts_pkg::*;

  logic nbar_t;
  logic internal_rst;
  logic prpg_en;
  logic srsg_en;
  logic sisa_en;
  logic misr_en;
  logic done;
`ifdef RTS_STATUS_EN
  logic                            busy;
  logic [cnt_w(NUM_TST_CYCL)-1:0]  tst_cycle;

  modport master (
    output nbar_t, internal_rst, prpg_en, srsg_en, sisa_en, misr_en, done,
    output busy, tst_cycle
  );
  modport slave (
    input nbar_t, internal_rst, prpg_en, srsg_en, sisa_en, misr_en, done,
    input busy, tst_cycle
  );
`else
  modport master (
    output nbar_t, internal_rst, prpg_en, srsg_en, sisa_en, misr_en, done
  );
  modport slave (
    input nbar_t, internal_rst, prpg_en, srsg_en, sisa_en, misr_en, done
  );
`endif
endinterface

// File: rtl/rts_counter.sv
// Saturating up-counter with async clear, sync clear, enable and a flag
// marking the last count (MAX-1) before the phase ends.
module rts_counter
  import rts_pkg::*;
#(
  parameter int MAX   = 1,
  parameter int WIDTH = cnt_w(MAX)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             last
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] LAST_V = WIDTH'(MAX - 1);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en && (count_reg != MAX_V)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;
  assign last  = (count_reg == LAST_V);

endmodule

// File: rtl/rts_controller.sv
// RTS BIST sequencer: reset pulse, then SHIFT_CNT shift clocks + 1 capture clock
// repeated NUM_TST_CYCL times, then sticky done. Optional status via RTS_STATUS_EN.
module rts_controller
  import rts_pkg::*;
#(
  parameter int SHIFT_CNT    = 1,
  parameter int NUM_TST_CYCL = 100
) (
  input  logic clk,
  input  logic rst,
  rts_if.master ctl
);

  localparam int SHIFT_W = cnt_w(SHIFT_CNT);
  localparam int CYC_W   = cnt_w(NUM_TST_CYCL);

  localparam logic [1:0] ST_RESET   = 2'(RESET);
  localparam logic [1:0] ST_SHIFT   = 2'(SHIFT);
  localparam logic [1:0] ST_CAPTURE = 2'(CAPTURE);
  localparam logic [1:0] ST_DONE    = 2'(DONE);

  logic [1:0]         state_reg;
  logic [1:0]         state_next;
  logic [SHIFT_W-1:0] shift_cnt;
  logic               shift_last;
  logic [CYC_W-1:0]   cyc_cnt;
  logic               cyc_last;

  // Shift counter restarts from zero every time SHIFT is entered.
  rts_counter #(.MAX(SHIFT_CNT), .WIDTH(SHIFT_W)) u_shift_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_reg != ST_SHIFT),
    .en    (state_reg == ST_SHIFT),
    .count (shift_cnt),
    .last  (shift_last)
  );

  rts_counter #(.MAX(NUM_TST_CYCL), .WIDTH(CYC_W)) u_cyc_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .en    (state_reg == ST_CAPTURE),
    .count (cyc_cnt),
    .last  (cyc_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_RESET;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RESET:   state_next = ST_SHIFT;
      ST_SHIFT:   if (shift_last) state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = cyc_last ? ST_DONE : ST_SHIFT;
      ST_DONE:    state_next = ST_DONE;
      default:    state_next = ST_RESET;
    endcase
  end

  // Moore decode: outputs depend only on the state register.
  logic nbar_t_next, internal_rst_next, prpg_en_next, srsg_en_next;
  logic sisa_en_next, misr_en_next, done_next;

  always_comb begin
    nbar_t_next       = 1'b1;
    internal_rst_next = 1'b0;
    prpg_en_next      = 1'b0;
    srsg_en_next      = 1'b0;
    sisa_en_next      = 1'b0;
    misr_en_next      = 1'b0;
    done_next         = 1'b0;
    case (state_reg)
      ST_RESET: internal_rst_next = 1'b1;
      ST_SHIFT: begin
        srsg_en_next = 1'b1;
        sisa_en_next = 1'b1;
      end
      ST_CAPTURE: begin
        nbar_t_next  = 1'b0;
        prpg_en_next = 1'b1;
        misr_en_next = 1'b1;
      end
      ST_DONE:  done_next = 1'b1;
      default:  internal_rst_next = 1'b1;
    endcase
  end

  assign ctl.nbar_t       = nbar_t_next;
  assign ctl.internal_rst = internal_rst_next;
  assign ctl.prpg_en      = prpg_en_next;
  assign ctl.srsg_en      = srsg_en_next;
  assign ctl.sisa_en      = sisa_en_next;
  assign ctl.misr_en      = misr_en_next;
  assign ctl.done         = done_next;

`ifdef RTS_STATUS_EN
  assign ctl.busy      = (state_reg == ST_SHIFT) || (state_reg == ST_CAPTURE);
  assign ctl.tst_cycle = cyc_cnt;

  logic unused_cnt;
  assign unused_cnt = ^shift_cnt;
`else
  logic unused_cnt;
  assign unused_cnt = ^{shift_cnt, cyc_cnt};
`endif

endmodule

// File: tb/tb_rts_controller.sv
// Directed bench for rts_controller: three instances (1/100, 3/2, 1/1) checked
// cycle by cycle against a state-sequence model; status checks under RTS_STATUS_EN.
module tb_rts_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  logic rst2 = 1'b1;

  int checks = 0;
  int errors = 0;

  // {nbar_t, internal_rst, prpg_en, srsg_en, sisa_en, misr_en, done}
  localparam logic [6:0] V_RESET = 7'b1100000;
  localparam logic [6:0] V_SHIFT = 7'b1001100;
  localparam logic [6:0] V_CAPT  = 7'b0010010;
  localparam logic [6:0] V_DONE  = 7'b1000001;

  rts_if #(.NUM_TST_CYCL(100)) if0 ();
  rts_if #(.NUM_TST_CYCL(2))   if1 ();
  rts_if #(.NUM_TST_CYCL(1))   if2 ();

  rts_controller #(.SHIFT_CNT(1), .NUM_TST_CYCL(100)) u0 (.clk(clk), .rst(rst0), .ctl(if0));
  rts_controller #(.SHIFT_CNT(3), .NUM_TST_CYCL(2))   u1 (.clk(clk), .rst(rst1), .ctl(if1));
  rts_controller #(.SHIFT_CNT(1), .NUM_TST_CYCL(1))   u2 (.clk(clk), .rst(rst2), .ctl(if2));

  function automatic logic [6:0] get_vec(input int which);
    case (which)
      0:       return {if0.nbar_t, if0.internal_rst, if0.prpg_en, if0.srsg_en,
                       if0.sisa_en, if0.misr_en, if0.done};
      1:       return {if1.nbar_t, if1.internal_rst, if1.prpg_en, if1.srsg_en,
                       if1.sisa_en, if1.misr_en, if1.done};
      default: return {if2.nbar_t, if2.internal_rst, if2.prpg_en, if2.srsg_en,
                       if2.sisa_en, if2.misr_en, if2.done};
    endcase
  endfunction

`ifdef RTS_STATUS_EN
  function automatic int get_tc(input int which);
    case (which)
      0:       return int'(if0.tst_cycle);
      1:       return int'(if1.tst_cycle);
      default: return int'(if2.tst_cycle);
    endcase
  endfunction

  function automatic logic get_busy(input int which);
    case (which)
      0:       return if0.busy;
      1:       return if1.busy;
      default: return if2.busy;
    endcase
  endfunction
`endif

  // Expected outputs after posedge e (counted from rst release); e=0 means still in RESET.
  function automatic logic [6:0] exp_vec(input int e, input int s, input int n);
    int p;
    if (e == 0) return V_RESET;
    if (e >= 1 + n * (s + 1)) return V_DONE;
    p = (e - 1) % (s + 1);
    return (p < s) ? V_SHIFT : V_CAPT;
  endfunction

  task automatic set_rst(input int which, input logic v);
    case (which)
      0:       rst0 = v;
      1:       rst1 = v;
      default: rst2 = v;
    endcase
  endtask

  task automatic test_reset();
    logic [6:0] v;
    @(negedge clk);
    set_rst(0, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    set_rst(0, 1'b1);
    #1;
    v = get_vec(0);
    checks++;
    if (v !== V_RESET) begin
      errors++;
      $display("FAIL reset_async got=%b exp=%b", v, V_RESET);
    end
    @(posedge clk); #1;
    v = get_vec(0);
    checks++;
    if (v !== V_RESET) begin
      errors++;
      $display("FAIL reset_hold got=%b exp=%b", v, V_RESET);
    end
    $display("test_reset: outputs=%b", v);
  endtask

  task automatic test_session(input int which, input int s, input int n, input int abort_e);
    logic [6:0] v;
    logic [6:0] ev;
    int last_e;
    int shift_n;
    int cap_n;
    last_e  = 1 + n * (s + 1);
    shift_n = 0;
    cap_n   = 0;
    @(negedge clk);
    set_rst(which, 1'b1);
    #1;
    v = get_vec(which);
    checks++;
    if (v !== V_RESET) begin
      errors++;
      $display("FAIL sess%0d_rst_pulse got=%b exp=%b", which, v, V_RESET);
    end
    set_rst(which, 1'b0);
    #1;
    v = get_vec(which);
    checks++;
    if (v !== V_RESET) begin
      errors++;
      $display("FAIL sess%0d_rst_release got=%b exp=%b", which, v, V_RESET);
    end
    for (int e = 1; e <= last_e; e++) begin
      @(posedge clk); #1;
      v  = get_vec(which);
      ev = exp_vec(e, s, n);
      checks++;
      if (v !== ev) begin
        errors++;
        $display("FAIL sess%0d_edge%0d got=%b exp=%b", which, e, v, ev);
      end
      checks++;
      if ((v[3] | v[2]) && (v[4] | v[1])) begin
        errors++;
        $display("FAIL sess%0d_excl_edge%0d got=%b exp=one_pair", which, e, v);
      end
      if (v[3]) shift_n++;
      if (v[4]) cap_n++;
`ifdef RTS_STATUS_EN
      if (e == 1) begin
        checks++;
        if (get_busy(which) !== 1'b1 || get_tc(which) != 0) begin
          errors++;
          $display("FAIL sess%0d_status_start got=busy%b/tc%0d exp=busy1/tc0",
                   which, get_busy(which), get_tc(which));
        end
      end
      if (e == last_e) begin
        checks++;
        if (get_busy(which) !== 1'b0 || get_tc(which) != n) begin
          errors++;
          $display("FAIL sess%0d_status_done got=busy%b/tc%0d exp=busy0/tc%0d",
                   which, get_busy(which), get_tc(which), n);
        end
      end
`endif
      if (e == abort_e) begin
        #1;
        set_rst(which, 1'b1);
        #1;
        v = get_vec(which);
        checks++;
        if (v !== V_RESET) begin
          errors++;
          $display("FAIL sess%0d_abort got=%b exp=%b", which, v, V_RESET);
        end
        $display("test_session[%0d] S=%0d N=%0d aborted at edge %0d outputs=%b",
                 which, s, n, e, v);
        return;
      end
    end
    checks++;
    if (shift_n != n * s) begin
      errors++;
      $display("FAIL sess%0d_shift_cycles got=%0d exp=%0d", which, shift_n, n * s);
    end
    checks++;
    if (cap_n != n) begin
      errors++;
      $display("FAIL sess%0d_capture_cycles got=%0d exp=%0d", which, cap_n, n);
    end
    $display("test_session[%0d] S=%0d N=%0d done at edge %0d shifts=%0d captures=%0d",
             which, s, n, last_e, shift_n, cap_n);
  endtask

  task automatic test_done_hold(input int which, input int n);
    logic [6:0] v;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      v = get_vec(which);
      checks++;
      if (v !== V_DONE) begin
        errors++;
        $display("FAIL hold%0d_cycle%0d got=%b exp=%b", which, i, v, V_DONE);
      end
`ifdef RTS_STATUS_EN
      checks++;
      if (get_tc(which) != n) begin
        errors++;
        $display("FAIL hold%0d_tc_cycle%0d got=%0d exp=%0d", which, i, get_tc(which), n);
      end
`endif
    end
    #1;
    set_rst(which, 1'b1);
    #1;
    v = get_vec(which);
    checks++;
    if (v !== V_RESET) begin
      errors++;
      $display("FAIL hold%0d_rst_clear got=%b exp=%b", which, v, V_RESET);
    end
    $display("test_done_hold[%0d] N=%0d held 20 cycles, rst outputs=%b", which, n, v);
  endtask

  initial begin
    test_reset();
    test_session(0, 1, 100, 0);
    test_done_hold(0, 100);
    test_session(0, 1, 100, 99);
    test_session(0, 1, 100, 0);
    test_session(1, 3, 2, 0);
    test_done_hold(1, 2);
    test_session(2, 1, 1, 0);
    test_done_hold(2, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
